ysyx_040729_idu_wb_scheduler: RTL



---
 rtl/ysyx_040729_pkg.sv | 19 +
 rtl/ysyx_040729_wb_rr_arbiter.sv | 35 +++
 rtl/ysyx_040729_idu_wb_scheduler.sv | 114 +++++++++++
 3 files changed

// File: rtl/ysyx_040729_pkg.sv
// Shared types and defaults for the IDU writeback scheduler slice.
package ysyx_040729_pkg;

  localparam int DEF_REGI_DEPTH = 32;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_AW         = $clog2(DEF_REGI_DEPTH);

  // Pending-write counter ceiling: at most three writes in flight per register.
  localparam logic [1:0] CNT_MAX = 2'd3;

  typedef logic [DEF_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic                      valid;
    reg_addr_t                 rd;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/ysyx_040729_wb_rr_arbiter.sv
// Two-input round-robin arbiter for the register-file write slot.
// A grant is also the acceptance of that request.
module ysyx_040729_wb_rr_arbiter
  import ysyx_040729_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  wb_req_t exu_req,
  input  wb_req_t lsu_req,
  output logic    exu_gnt,
  output logic    lsu_gnt,
  output wb_req_t sel_req
);

  // Set when LSU won the most recent contention; reset favours EXU next.
  logic last_lsu;

  // Grant the sole requester, or the one not granted at the last contention.
  always_comb begin
    exu_gnt       = exu_req.valid & (~lsu_req.valid | last_lsu);
    lsu_gnt       = lsu_req.valid & (~exu_req.valid | ~last_lsu);
    sel_req       = lsu_gnt ? lsu_req : exu_req;
    sel_req.valid = exu_gnt | lsu_gnt;
  end

  // Fairness flag moves only when both sources competed.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_lsu <= 1'b1;
    end else if (exu_req.valid && lsu_req.valid) begin
      last_lsu <= lsu_gnt;
    end
  end

endmodule

// File: rtl/ysyx_040729_idu_wb_scheduler.sv
// Register-file write-port scheduler: round-robin between EXU and LSU
// writeback, one registered write stage, and a per-register pending-write
// scoreboard that drives IDU read hazards and issue back-pressure.
module ysyx_040729_idu_wb_scheduler
  import ysyx_040729_pkg::*;
#(
  parameter  int REGI_DEPTH = DEF_REGI_DEPTH,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int AW         = $clog2(REGI_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  output logic                  issue_ready,
  input  logic [AW-1:0]         rs1,
  input  logic [AW-1:0]         rs2,
  output logic                  hazard1,
  output logic                  hazard2,
  input  logic                  exu_valid,
  input  logic [AW-1:0]         exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  output logic                  exu_ready,
  input  logic                  lsu_valid,
  input  logic [AW-1:0]         lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  output logic                  rf_wen,
  output logic [AW-1:0]         rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  // Saturating pending counter step; an increment and a decrement cancel.
  function automatic logic [1:0] cnt_next(input logic [1:0] cur,
                                          input logic       inc,
                                          input logic       dec);
    if (inc && !dec) return (cur == CNT_MAX) ? cur : cur + 2'd1;
    if (dec && !inc) return (cur == 2'd0) ? cur : cur - 2'd1;
    return cur;
  endfunction

  // A read is blocked while a write is pending, unless the only pending
  // write is on the port right now and the register file forwards it.
  function automatic logic src_hazard(input logic [AW-1:0] rs,
                                      input logic [1:0]    c,
                                      input logic          fwd);
    return (rs != '0) && (c != 2'd0) && !((c == 2'd1) && fwd);
  endfunction

  logic [1:0]    cnt [REGI_DEPTH];
  logic          issue_fire;
  wb_req_t       exu_req;
  wb_req_t       lsu_req;
  wb_req_t       sel_req;
  logic          wen_p1;
  logic [AW-1:0] waddr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;

  assign exu_req = {exu_valid, exu_rd, exu_data};
  assign lsu_req = {lsu_valid, lsu_rd, lsu_data};

  ysyx_040729_wb_rr_arbiter u_arb (
    .clock   (clock),
    .reset   (reset),
    .exu_req (exu_req),
    .lsu_req (lsu_req),
    .exu_gnt (exu_ready),
    .lsu_gnt (lsu_ready),
    .sel_req (sel_req)
  );

  // Issue back-pressure and read hazards, seen against this cycle's commit.
  always_comb begin
    issue_ready = !((issue_rd != '0) && (cnt[issue_rd] == CNT_MAX) &&
                    !(rf_wen && (rf_waddr == issue_rd)));
    issue_fire  = issue_valid && issue_ready;
    hazard1     = src_hazard(rs1, cnt[rs1], rf_wen && (rf_waddr == rs1));
    hazard2     = src_hazard(rs2, cnt[rs2], rf_wen && (rf_waddr == rs2));
  end

  // Scoreboard: count up on issue, down on commit; x0 is never tracked.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REGI_DEPTH; i++) cnt[i] <= 2'd0;
    end else begin
      cnt[0] <= 2'd0;
      for (int i = 1; i < REGI_DEPTH; i++) begin
        cnt[i] <= cnt_next(cnt[i],
                           issue_fire && (issue_rd == AW'(i)),
                           rf_wen && (rf_waddr == AW'(i)));
      end
    end
  end

  // Stage p0 -> p1: accepted request becomes the register-file write.
  always_ff @(posedge clock) begin
    if (reset) begin
      wen_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      wen_p1 <= sel_req.valid && (sel_req.rd != '0);
      if (sel_req.valid) begin
        waddr_p1 <= sel_req.rd;
        wdata_p1 <= sel_req.data;
      end
    end
  end

  assign rf_wen   = wen_p1;
  assign rf_waddr = waddr_p1;
  assign rf_wdata = wdata_p1;

endmodule
